adc_conv_sequencer: RTL

ADC_CONV_SEQUENCER -- requirements
Module: adc_conv_sequencer

---
 rtl/adc_conv_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/adc_conv_sequencer.sv
// ---------------------------------------------------------------------------
// adc_conv_sequencer
//   Runs a parallel-output ADC at a fixed conversion rate. Each period starts
//   with a CONVST pulse, waits for the ADC's end-of-conversion falling edge,
//   captures the data bus and then idles out the rest of the period. A
//   conversion the ADC never finishes is abandoned after TIMEOUT clocks and
//   counted. Captured samples are also block-averaged over 2^AVG_LOG2 samples.
//
// Parameters
//   CLK_DIV       clocks per conversion period (64..65535)
//   CONVST_WIDTH  clocks o_convst is held high (1..TIMEOUT-1)
//   TIMEOUT       clocks from CONVST rise before a conversion is abandoned
//   AVG_LOG2      log2 of the averaging block size (0..4)
//
// Ports
//   i_CLK        clock, rising edge
//   i_RST        asynchronous active-low reset
//   i_enable     run request (sampled at period boundaries)
//   i_data[7:0]  ADC data bus (asynchronous)
//   i_eoc        ADC end-of-conversion, falling edge = data valid (asynchronous)
//   o_convst     conversion-start pulse to the ADC
//   o_data[7:0]  last captured sample,  o_valid     one-cycle update strobe
//   o_avg[7:0]   last block average,    o_avg_valid one-cycle update strobe
//   o_timeout    one-cycle pulse when a conversion is abandoned
//   o_err_cnt    saturating timeout count
//   o_busy       high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module adc_conv_sequencer #(
  parameter int CLK_DIV      = 1000,
  parameter int CONVST_WIDTH = 10,
  parameter int TIMEOUT      = 500,
  parameter int AVG_LOG2     = 2
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_enable,
  input  logic [7:0] i_data,
  input  logic       i_eoc,
  output logic       o_convst,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic [7:0] o_avg,
  output logic       o_avg_valid,
  output logic       o_timeout,
  output logic [7:0] o_err_cnt,
  output logic       o_busy
);

  localparam int          ACC_W        = 8 + AVG_LOG2;
  localparam logic [15:0] START_LAST   = 16'(CONVST_WIDTH - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] PERIOD_LAST  = 16'(CLK_DIV - 1);
  localparam logic [4:0]  BLOCK_LAST   = 5'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  state_t             state, state_next;
  logic [15:0]        period_cnt, period_cnt_next;

  logic               eoc_s1, eoc_s2, eoc_s3, eoc_fall;
  logic [7:0]         data_s1, data_s2, data_cap;

  logic               capture, abandon;
  logic [ACC_W-1:0]   acc, sum;
  logic [4:0]         sample_cnt;

  // Synchronizers. The data bus goes through the same number of stages as
  // EOC so that the word registered alongside the detected edge is the one
  // that was on the bus when EOC was first seen low. A third stage forms the
  // edge detector; the edge and its data word are registered once more so the
  // FSM acts on clean flops.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      eoc_s1   <= 1'b1;
      eoc_s2   <= 1'b1;
      eoc_s3   <= 1'b1;
      eoc_fall <= 1'b0;
      data_s1  <= 8'd0;
      data_s2  <= 8'd0;
      data_cap <= 8'd0;
    end else begin
      eoc_s1   <= i_eoc;
      eoc_s2   <= eoc_s1;
      eoc_s3   <= eoc_s2;
      eoc_fall <= eoc_s3 & ~eoc_s2;
      data_s1  <= i_data;
      data_s2  <= data_s1;
      data_cap <= data_s2;
    end
  end

  // Next-state logic. Counter comparisons use the "about to reach" value so
  // the registered strobes land exactly on the counted clock.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    abandon    = 1'b0;
    case (state)
      IDLE:  if (i_enable) state_next = START;
      START: if (period_cnt >= START_LAST) state_next = WAIT;
      WAIT: begin
        // A real EOC edge wins over a simultaneous timeout.
        if (eoc_fall) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else if (period_cnt >= TIMEOUT_LAST) begin
          abandon    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD:  if (period_cnt >= PERIOD_LAST) state_next = i_enable ? START : IDLE;
      default: state_next = IDLE;
    endcase

    if (state_next == START && state != START) period_cnt_next = 16'd0;
    else                                       period_cnt_next = period_cnt + 16'd1;
  end

  assign sum      = acc + ACC_W'(data_cap);
  assign o_convst = (state == START);
  assign o_busy   = (state != IDLE);

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state       <= IDLE;
      period_cnt  <= 16'd0;
      o_data      <= 8'd0;
      o_valid     <= 1'b0;
      o_avg       <= 8'd0;
      o_avg_valid <= 1'b0;
      o_timeout   <= 1'b0;
      o_err_cnt   <= 8'd0;
      acc         <= '0;
      sample_cnt  <= 5'd0;
    end else begin
      state       <= state_next;
      period_cnt  <= period_cnt_next;
      o_valid     <= capture;
      o_avg_valid <= 1'b0;
      o_timeout   <= abandon;

      if (capture) begin
        o_data <= data_cap;
        if (sample_cnt == BLOCK_LAST) begin
          // Block complete: publish the truncated mean and start a new block.
          o_avg       <= sum[ACC_W-1:AVG_LOG2];
          o_avg_valid <= 1'b1;
          acc         <= '0;
          sample_cnt  <= 5'd0;
        end else begin
          acc        <= sum;
          sample_cnt <= sample_cnt + 5'd1;
        end
      end

      if (abandon && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

endmodule
